i2s_playback_ctrl: RTL and testbench

Playback sequencer that sits between the CPU/DMA sample path and `i2sSlaveUnit`. It buffers 32-bit sample words in an internal FIFO and primes the unit before asserting `playback`. It answers each `readReq` with the next word, handles underrun with silence, and drains cleanly on stop. It also owns the `sampleSize`/`stereoMode` configuration so the unit is only reconfigured while idle.

---
 rtl/i2s_playback_ctrl.sv | 175 +++++++++++++++++
 tb/tb_i2s_playback_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_playback_ctrl.sv
// Playback sequencer for i2sSlaveUnit: buffers sample words in a FIFO, primes the
// first word before raising playback, answers readReq edges and drains on stop.
module i2s_playback_ctrl #(
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 4,
  parameter int LOW_MARK    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           cfgSampleSize,
  input  logic                           cfgStereoMode,
  input  logic                           cfgStopOnUnderrun,
  input  logic [31:0]                    wrData,
  input  logic                           wrValid,
  output logic                           wrReady,
  input  logic                           readReq,
  output logic                           playback,
  output logic                           sampleSize,
  output logic                           stereoMode,
  output logic [31:0]                    sampleData,
  output logic [$clog2(DEPTH+1)-1:0]     fifoLevel,
  output logic                           lowWater,
  output logic                           underrun,
  input  logic                           underrunClr,
  output logic                           busy
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);
  localparam logic [LW-1:0] LOW_LVL   = LW'(LOW_MARK);
  localparam logic [LW-1:0] ZERO_LVL  = LW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            read_req_q, read_req_d;
  logic            req_q, req_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [31:0]     sample_data_q, sample_data_d;
  logic            underrun_q, underrun_d;
  logic            playback_q, playback_d;
  logic            sample_size_q, sample_size_d;
  logic            stereo_mode_q, stereo_mode_d;
  logic [31:0]     mem_q [DEPTH];

  logic            push_s;
  logic            pop_s;
  logic            underrun_set_s;
  logic            empty_s;

  // Next-state, FIFO bookkeeping and output computation.
  always_comb begin
    push_s         = wrValid & (level_q != FULL_LVL);
    empty_s        = (level_q == ZERO_LVL);
    pop_s          = 1'b0;
    underrun_set_s = 1'b0;
    state_d        = state_q;
    sample_data_d  = sample_data_q;
    sample_size_d  = sample_size_q;
    stereo_mode_d  = stereo_mode_q;
    read_req_d     = readReq;
    req_d          = readReq & ~read_req_q;

    case (state_q)
      IDLE: begin
        sample_size_d = cfgSampleSize;
        stereo_mode_d = cfgStereoMode;
        if (enable && (level_q >= PRIME_LVL)) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (!empty_s) begin
          pop_s         = 1'b1;
          sample_data_d = mem_q[rd_ptr_q];
        end else begin
          sample_data_d = 32'd0;
        end
        state_d = RUN;
      end
      RUN, DRAIN: begin
        if (req_q && !empty_s) begin
          pop_s         = 1'b1;
          sample_data_d = mem_q[rd_ptr_q];
        end else if (req_q) begin
          sample_data_d  = 32'd0;
          underrun_set_s = (state_q == RUN);
        end else begin
          sample_data_d = sample_data_q;
        end
        // An empty request ends a drain; in RUN it only ends playback when configured to.
        if (req_q && empty_s && ((state_q == DRAIN) || cfgStopOnUnderrun)) begin
          state_d = IDLE;
        end else if (enable) begin
          state_d = RUN;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    underrun_d = underrun_set_s | (underrun_q & ~underrunClr);
    playback_d = (state_d == RUN) || (state_d == DRAIN);
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      read_req_q    <= 1'b0;
      req_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      sample_data_q <= 32'd0;
      underrun_q    <= 1'b0;
      playback_q    <= 1'b0;
      sample_size_q <= 1'b0;
      stereo_mode_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      read_req_q    <= read_req_d;
      req_q         <= req_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      sample_data_q <= sample_data_d;
      underrun_q    <= underrun_d;
      playback_q    <= playback_d;
      sample_size_q <= sample_size_d;
      stereo_mode_q <= stereo_mode_d;
    end
  end

  // Sample storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wrData;
    end
  end

  assign wrReady    = (level_q != FULL_LVL);
  assign lowWater   = (level_q <= LOW_LVL);
  assign fifoLevel  = level_q;
  assign sampleData = sample_data_q;
  assign underrun   = underrun_q;
  assign playback   = playback_q;
  assign sampleSize = sample_size_q;
  assign stereoMode = stereo_mode_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_i2s_playback_ctrl.sv
// Directed and randomized bench for i2s_playback_ctrl against a queue-based reference model.
module tb_i2s_playback_ctrl;
  localparam int DEPTH = 16;
  localparam int PRIME = 4;
  localparam int LOWM  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, cfgSampleSize, cfgStereoMode, cfgStopOnUnderrun;
  logic [31:0] wrData;
  logic        wrValid, wrReady, readReq, playback, sampleSize, stereoMode;
  logic [31:0] sampleData;
  logic [4:0]  fifoLevel;
  logic        lowWater, underrun, underrunClr, busy;

  i2s_playback_ctrl #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME), .LOW_MARK(LOWM)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfgSampleSize(cfgSampleSize),
    .cfgStereoMode(cfgStereoMode), .cfgStopOnUnderrun(cfgStopOnUnderrun),
    .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady), .readReq(readReq),
    .playback(playback), .sampleSize(sampleSize), .stereoMode(stereoMode),
    .sampleData(sampleData), .fifoLevel(fifoLevel), .lowWater(lowWater),
    .underrun(underrun), .underrunClr(underrunClr), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 idle, 1 priming, 2 playing, 3 draining.
  logic [31:0] q[$];
  int          mode;
  bit          pend, prev_rr, m_und, m_ss, m_sm;
  logic [31:0] m_sd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode = 0; pend = 1'b0; prev_rr = 1'b0;
    m_sd = 32'd0; m_und = 1'b0; m_ss = 1'b0; m_sm = 1'b0;
  endtask

  task automatic model_step();
    bit push, svc, empty, set;
    int nmode;
    push  = wrValid && (q.size() < DEPTH);
    empty = (q.size() == 0);
    svc   = pend;
    set   = 1'b0;
    nmode = mode;
    if (mode == 0) begin
      m_ss = cfgSampleSize;
      m_sm = cfgStereoMode;
      if (enable && q.size() >= PRIME) nmode = 1;
    end else if (mode == 1) begin
      m_sd  = q.pop_front();
      nmode = 2;
    end else begin
      if (svc && !empty) m_sd = q.pop_front();
      else if (svc) begin
        m_sd = 32'd0;
        if (mode == 2) begin
          set = 1'b1;
          if (cfgStopOnUnderrun) nmode = 0;
        end else nmode = 0;
      end
      if (nmode != 0) nmode = enable ? 2 : 3;
    end
    m_und = set ? 1'b1 : (underrunClr ? 1'b0 : m_und);
    if (push) q.push_back(wrData);
    pend    = readReq && !prev_rr;
    prev_rr = readReq;
    mode    = nmode;
  endtask

  task automatic compare_all();
    chk("playback",   {31'd0, playback},   {31'd0, (mode == 2 || mode == 3)});
    chk("busy",       {31'd0, busy},       {31'd0, (mode != 0)});
    chk("sampleData", sampleData,          m_sd);
    chk("fifoLevel",  {27'd0, fifoLevel},  q.size());
    chk("wrReady",    {31'd0, wrReady},    {31'd0, (q.size() < DEPTH)});
    chk("lowWater",   {31'd0, lowWater},   {31'd0, (q.size() <= LOWM)});
    chk("underrun",   {31'd0, underrun},   {31'd0, m_und});
    chk("sampleSize", {31'd0, sampleSize}, {31'd0, m_ss});
    chk("stereoMode", {31'd0, stereoMode}, {31'd0, m_sm});
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_playback", {31'd0, playback}, 32'd0);
    chk("rst_level",    {27'd0, fifoLevel}, 32'd0);
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse(input int hold, input int gap);
    readReq = 1'b1;
    cyc(hold);
    readReq = 1'b0;
    cyc(gap);
  endtask

  initial begin
    logic [31:0] w [4];
    enable = 1'b0; cfgSampleSize = 1'b0; cfgStereoMode = 1'b0; cfgStopOnUnderrun = 1'b0;
    wrData = 32'd0; wrValid = 1'b0; readReq = 1'b0; underrunClr = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_wrReady",  {31'd0, wrReady},  32'd1);
    chk("rst_lowWater", {31'd0, lowWater}, 32'd1);
    cyc(2);

    // Prime and start.
    for (int i = 1; i <= 4; i++) begin
      wrData = 32'h11111111 * i;
      wrValid = 1'b1;
      cyc(1);
    end
    wrValid = 1'b0;
    enable = 1'b1;
    cyc(1);
    chk("start_pb_early", {31'd0, playback}, 32'd0);
    cyc(1);
    chk("start_pb",  {31'd0, playback}, 32'd1);
    chk("start_sd",  sampleData, 32'h11111111);
    chk("start_lvl", {27'd0, fifoLevel}, 32'd3);

    // Request stepping: held-high requests count once, word lands two cycles after the edge.
    for (int i = 2; i <= 4; i++) begin
      readReq = 1'b1;
      cyc(1);
      chk("step_hold", sampleData, 32'h11111111 * (i - 1));
      cyc(1);
      chk("step_sd", sampleData, 32'h11111111 * i);
      cyc(3);
      readReq = 1'b0;
      cyc(3);
    end
    chk("step_lvl", {27'd0, fifoLevel}, 32'd0);

    // Underrun, continue playing.
    cfgStopOnUnderrun = 1'b0;
    pulse(2, 2);
    chk("ur_sd",   sampleData, 32'd0);
    chk("ur_flag", {31'd0, underrun}, 32'd1);
    chk("ur_busy", {31'd0, busy}, 32'd1);
    underrunClr = 1'b1;
    cyc(1);
    underrunClr = 1'b0;
    chk("ur_clr", {31'd0, underrun}, 32'd0);

    // Underrun, stop.
    cfgStopOnUnderrun = 1'b1;
    readReq = 1'b1;
    cyc(2);
    chk("urs_busy", {31'd0, busy}, 32'd0);
    chk("urs_pb",   {31'd0, playback}, 32'd0);
    readReq = 1'b0;
    underrunClr = 1'b1;
    cyc(1);
    underrunClr = 1'b0;
    cfgStopOnUnderrun = 1'b0;
    cyc(1);

    // Drain with a config change that must wait for idle.
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      wrData = w[i];
      wrValid = 1'b1;
      cyc(1);
    end
    wrValid = 1'b0;
    cyc(3);
    pulse(2, 2);
    chk("dr_pre_lvl", {27'd0, fifoLevel}, 32'd2);
    enable = 1'b0;
    cyc(1);
    cfgSampleSize = 1'b1;
    cyc(1);
    chk("dr_ss_frozen", {31'd0, sampleSize}, 32'd0);
    pulse(2, 2);
    chk("dr_w2", sampleData, w[2]);
    pulse(2, 2);
    chk("dr_w3", sampleData, w[3]);
    readReq = 1'b1;
    cyc(2);
    chk("dr_sd0",  sampleData, 32'd0);
    chk("dr_idle", {31'd0, busy}, 32'd0);
    chk("dr_ur",   {31'd0, underrun}, 32'd0);
    readReq = 1'b0;
    cyc(2);
    chk("dr_ss_idle", {31'd0, sampleSize}, 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      wrValid = ($urandom_range(0, 99) < 40);
      wrData  = $urandom;
      if ($urandom_range(0, 99) < 30) readReq = ~readReq;
      if ($urandom_range(0, 99) < 4) enable = ~enable;
      if ($urandom_range(0, 99) < 3) cfgStopOnUnderrun = ~cfgStopOnUnderrun;
      cfgSampleSize = $urandom_range(0, 1);
      cfgStereoMode = $urandom_range(0, 1);
      underrunClr   = ($urandom_range(0, 99) < 5);
      if (n % 1000 == 999) do_reset();
      cyc(1);
    end

    // Full FIFO, then reset in the middle of playback.
    wrValid = 1'b0; readReq = 1'b0; enable = 1'b0; underrunClr = 1'b0;
    do_reset();
    wrValid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wrData = 32'h0A000000 + i;
      cyc(1);
      if (i == 15) begin
        chk("full_ready", {31'd0, wrReady}, 32'd0);
        chk("full_lvl",   {27'd0, fifoLevel}, 32'd16);
      end
    end
    chk("full_17_lvl", {27'd0, fifoLevel}, 32'd16);
    wrValid = 1'b0;
    enable = 1'b1;
    cyc(4);
    chk("run_pb", {31'd0, playback}, 32'd1);
    chk("run_sd", sampleData, 32'h0A000000);
    #2;
    do_reset();
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
